// File: rtl/qpmm_arbiter.sv
// qpmm_arbiter: round-robin sharing of one pipelined QPMM among N_REQ requesters.
// Each accepted operand pair carries a {valid, id} tag that rides alongside the QPMM pipeline.
module qpmm_arbiter #(
    parameter int N_REQ = 4,
    parameter int LAT = 82,
    parameter int W = 398,
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int IW = $clog2(LAT + 2)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [W-1:0]       q_a,
    output logic [W-1:0]       q_b,
    input  logic [W-1:0]       q_z,
    output logic [N_REQ-1:0]   resp_valid,
    output logic [W-1:0]       resp_z,
    output logic [IW-1:0]      inflight,
    output logic               idle
);
    logic [PW-1:0] ptr, gnt;
    logic          acc;
    logic [LAT:0]  tag_v;
    logic [PW-1:0] tag_id [0:LAT];

    // Walk offsets high-to-low so the requester closest to ptr wins last.
    always_comb begin
        gnt = ptr;
        acc = 1'b0;
        for (int o = N_REQ - 1; o >= 0; o--) begin
            if (enable && req_valid[(int'(ptr) + o) % N_REQ]) begin
                gnt = PW'((int'(ptr) + o) % N_REQ);
                acc = 1'b1;
            end
        end
        req_ready = acc ? (N_REQ'(1) << gnt) : '0;
    end

    assign idle = (inflight == '0);

    // Stage 0 launches with the operand registers; stage LAT lines up with q_z.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr        <= '0;
            q_a        <= '0;
            q_b        <= '0;
            tag_v      <= '0;
            resp_valid <= '0;
            resp_z     <= '0;
            inflight   <= '0;
        end else begin
            if (acc) begin
                ptr <= (gnt == PW'(N_REQ - 1)) ? '0 : gnt + PW'(1);
                q_a <= req_a[gnt*W +: W];
                q_b <= req_b[gnt*W +: W];
            end
            tag_v      <= {tag_v[LAT-1:0], acc};
            resp_valid <= tag_v[LAT] ? (N_REQ'(1) << tag_id[LAT]) : '0;
            if (tag_v[LAT])
                resp_z <= q_z;
            inflight <= inflight + IW'(acc) - IW'(tag_v[LAT]);
        end
    end

    always_ff @(posedge clk) begin
        tag_id[0] <= gnt;
        for (int j = 1; j <= LAT; j++)
            tag_id[j] <= tag_id[j-1];
    end
endmodule
